mux_arbiter_3: RTL and testbench
================================

Name: mux_arbiter_3

Overview:
Round-robin arbiter that shares one 16-bit, 3-input selection datapath (select encodings 000/001/010) between three requesters, e.g. fetch, load/store and debug port.
- Produces the registered 3-bit select and a one-hot grant.
- Holds ownership until the shared resource signals completion.
- Enforces a maximum hold time so no requester can starve the others.
- Sits between the requesters and the operand/data mux in the core.

Parameters:
MAX_HOLD, 16, maximum cycles one owner may keep the grant while others wait; 0 disables preemption.
CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  3  request per requester (bit i = requester i); held high until served.
done  input  1  shared resource has completed the current owner's transfer this cycle.
grant  output  3  one-hot grant, registered; 000 when idle.
select  output  3  mux select, registered: 000/001/010 = owner 0/1/2; 011 = idle (mux drives zero).
busy  output  1  high while a grant is active.
timeout  output  1  single-cycle pulse on the cycle a preemption handoff is registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, grant=000, select=011, busy=0, timeout=0, hold_cnt=0.
  - last_owner=2, so requester 0 has first priority.
  - rst has priority over every other input. Reset mid-grant drops the grant on the next edge with no completion.
- Round-robin pick (combinational) scans req starting at last_owner+1 (mod 3): first set bit wins.
- State IDLE:
  - If req!=0, register the winner: grant=onehot(w), select=w, busy=1, hold_cnt=0, last_owner=w, go to GRANT.
  - Latency: request seen at edge N, grant visible after edge N+1 (1 cycle). No req: remain IDLE.
- State GRANT:
  - hold_cnt increments each cycle, saturating at 2^CNT_W-1.
- Release: done=1, or req[owner]=0 (abort).
  - If other requests are pending, hand off directly to the next round-robin winner at the next edge, with no idle bubble. hold_cnt=0.
  - The current owner is lowest priority in the pick.
  - If nothing is pending, return to IDLE (grant=000, select=011, busy=0).
  - If req[owner] is still set together with done and no other requester is waiting, re-grant the same owner: hold_cnt=0 and grant stays high continuously.
- Preemption: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, no done, and any other req bit set.
  - Hand off to the next winner, excluding the owner; timeout=1 for that cycle.
  - The preempted requester keeps req high and re-competes normally.
- Simultaneous done and preemption condition: treat as a normal release, with timeout=0.
- grant and select always change on the same edge and are mutually consistent. select is never 1xx.
- Requests asserted while the resource is busy are not lost: they are sampled level-wise at each arbitration point.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT}.
  - Constants SEL_REQ0=3'b000, SEL_REQ1=3'b001, SEL_REQ2=3'b010, SEL_IDLE=3'b011.
  - Function onehot3(idx).
- One sub-module, rr_pick3: combinational. Inputs req[2:0], last[1:0], exclude_en, exclude_idx. Outputs valid and idx[1:0].

Test Plan:
1. Reset then req=001 at cycle 2 -> grant=001, select=000, busy=1 after edge 3. done at cycle 5 with req=000 -> grant=000, select=011, busy=0 after edge 6.
2. req=111 held, done pulsed every 3rd cycle -> owners rotate 0,1,2,0. Handoffs occur without an idle cycle. select follows 000,001,010,000.
3. MAX_HOLD=4: owner 1 holds with no done, req=011 -> after 4 cycles of grant, grant switches to 001 (owner 0) and timeout pulses once. Owner 1 is re-granted after owner 0's done.
4. Owner 2 drops req without done while req[0]=1 -> grant moves to owner 0 next edge, timeout=0.
5. rst asserted in GRANT with req=111 -> next edge grant=000, select=011. First grant after reset release goes to owner 0.
6. done coinciding with hold_cnt==MAX_HOLD-1 and req=111 -> normal handoff to next owner, timeout=0. Sole requester with MAX_HOLD reached -> keeps grant, no timeout.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, select encodings and helpers for the 3-way arbiter
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [2:0] SEL_REQ0 = 3'b000;
    localparam logic [2:0] SEL_REQ1 = 3'b001;
    localparam logic [2:0] SEL_REQ2 = 3'b010;
    localparam logic [2:0] SEL_IDLE = 3'b011;

    // One-hot of a requester index; index 3 is not a requester and maps to 000.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational round-robin pick over three requesters
module rr_pick3
    import arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       exclude_en,
    input  logic [1:0] exclude_idx,
    output logic       valid,
    output logic [1:0] idx
);

    logic [2:0] eligible;
    logic [1:0] cand;

    // Scan from the requester after 'last', wrapping, so 'last' is scanned last.
    always_comb begin
        eligible = req & ~(exclude_en ? onehot3(exclude_idx) : 3'b000);
        valid    = 1'b0;
        idx      = 2'd0;
        cand     = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!valid && eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

endmodule

// File: rtl/mux_arbiter_3.sv
// rtl/mux_arbiter_3.sv - round-robin owner arbiter with hold-time preemption for a 3-input mux
module mux_arbiter_3
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [2:0] select,
    output logic       busy,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT   = '1;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_d;
    logic [1:0]       last_owner;
    logic [1:0]       last_d;
    logic [2:0]       grant_d;
    logic [2:0]       select_d;
    logic             busy_d;
    logic             timeout_d;

    logic             owner_req;
    logic             others_pending;
    logic             release_now;
    logic             preempt;
    logic             pick_valid;
    logic [1:0]       pick_idx;

    // While granted, last_owner is the current owner.
    assign owner_req      = req[last_owner];
    assign others_pending = |(req & ~onehot3(last_owner));
    assign release_now    = done || !owner_req;
    assign preempt        = (MAX_HOLD != 0) && (state_q == GRANT) && (hold_cnt == HOLD_LIMIT)
                            && !release_now && others_pending;

    rr_pick3 u_pick (
        .req         (req),
        .last        (last_owner),
        .exclude_en  (preempt),
        .exclude_idx (last_owner),
        .valid       (pick_valid),
        .idx         (pick_idx)
    );

    // Next-state: arbitrate in IDLE, and on release or preemption while granted.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        select_d  = select;
        busy_d    = busy;
        timeout_d = 1'b0;
        hold_d    = hold_cnt;
        last_d    = last_owner;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    grant_d  = onehot3(pick_idx);
                    select_d = {1'b0, pick_idx};
                    busy_d   = 1'b1;
                    hold_d   = '0;
                    last_d   = pick_idx;
                end
            end
            GRANT: begin
                if (release_now || preempt) begin
                    hold_d = '0;
                    if (pick_valid) begin
                        grant_d   = onehot3(pick_idx);
                        select_d  = {1'b0, pick_idx};
                        last_d    = pick_idx;
                        timeout_d = preempt;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = 3'b000;
                        select_d = SEL_IDLE;
                        busy_d   = 1'b0;
                    end
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_d = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = 3'b000;
                select_d = SEL_IDLE;
                busy_d   = 1'b0;
                hold_d   = '0;
            end
        endcase
    end

    // State and registered outputs; last_owner resets to 2 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant      <= 3'b000;
            select     <= SEL_IDLE;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= 2'd2;
        end else begin
            state_q    <= state_d;
            grant      <= grant_d;
            select     <= select_d;
            busy       <= busy_d;
            timeout    <= timeout_d;
            hold_cnt   <= hold_d;
            last_owner <= last_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_3.sv
// tb/tb_mux_arbiter_3.sv - directed self-checking bench for mux_arbiter_3
module tb_mux_arbiter_3;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [2:0] select;
    logic       busy;
    logic       timeout;

    int n_tests;
    int n_fail;

    mux_arbiter_3 #(
        .MAX_HOLD (4),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .select  (select),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic [2:0] s,
                              input logic b, input logic t);
        check({tag, ".grant"},   {5'd0, grant},   {5'd0, g});
        check({tag, ".select"},  {5'd0, select},  {5'd0, s});
        check({tag, ".busy"},    {7'd0, busy},    {7'd0, b});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 3'b000;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [2:0] rot_grant [4];
    logic [2:0] rot_sel   [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        req  = 3'b000;
        done = 1'b0;

        // Reset state
        do_reset();
        expect_out("reset", 3'b000, 3'b011, 1'b0, 1'b0);

        // 1: single request, then completion with nothing pending
        req = 3'b001;
        step();
        expect_out("t1_grant", 3'b001, 3'b000, 1'b1, 1'b0);
        step();
        expect_out("t1_hold", 3'b001, 3'b000, 1'b1, 1'b0);
        req  = 3'b000;
        done = 1'b1;
        step();
        done = 1'b0;
        expect_out("t1_idle", 3'b000, 3'b011, 1'b0, 1'b0);

        // 2: all requesting, done every third cycle -> rotation 0,1,2,0 with no bubble
        do_reset();
        rot_grant[0] = 3'b001; rot_sel[0] = 3'b000;
        rot_grant[1] = 3'b010; rot_sel[1] = 3'b001;
        rot_grant[2] = 3'b100; rot_sel[2] = 3'b010;
        rot_grant[3] = 3'b001; rot_sel[3] = 3'b000;
        req = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            expect_out($sformatf("t2_own%0d", k), rot_grant[k], rot_sel[k], 1'b1, 1'b0);
            step();
            check($sformatf("t2_mid%0d", k), {5'd0, grant}, {5'd0, rot_grant[k]});
            step();
            done = 1'b1;
            step();
            done = 1'b0;
        end

        // 3: owner 1 preempted after 4 granted cycles, re-granted after owner 0 finishes
        do_reset();
        req = 3'b010;
        step();
        expect_out("t3_own1", 3'b010, 3'b001, 1'b1, 1'b0);
        req = 3'b011;
        step();
        step();
        step();
        expect_out("t3_before", 3'b010, 3'b001, 1'b1, 1'b0);
        step();
        expect_out("t3_preempt", 3'b001, 3'b000, 1'b1, 1'b1);
        step();
        expect_out("t3_after", 3'b001, 3'b000, 1'b1, 1'b0);
        req  = 3'b010;
        done = 1'b1;
        step();
        done = 1'b0;
        expect_out("t3_regrant1", 3'b010, 3'b001, 1'b1, 1'b0);

        // 4: owner 2 aborts with requester 0 waiting
        do_reset();
        req = 3'b100;
        step();
        expect_out("t4_own2", 3'b100, 3'b010, 1'b1, 1'b0);
        req = 3'b001;
        step();
        expect_out("t4_abort", 3'b001, 3'b000, 1'b1, 1'b0);

        // 5: reset while granted, then first grant goes to owner 0
        req = 3'b111;
        rst = 1'b1;
        step();
        expect_out("t5_rst", 3'b000, 3'b011, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("t5_first", 3'b001, 3'b000, 1'b1, 1'b0);

        // 6a: done at the hold limit -> plain handoff, no timeout
        step();
        step();
        step();
        expect_out("t6_limit", 3'b001, 3'b000, 1'b1, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        expect_out("t6_done_limit", 3'b010, 3'b001, 1'b1, 1'b0);

        // 6b: sole requester keeps the grant past the limit
        req = 3'b010;
        for (int k = 0; k < 6; k++) begin
            step();
            expect_out($sformatf("t6_sole%0d", k), 3'b010, 3'b001, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        expect_out("t6_regrant", 3'b010, 3'b001, 1'b1, 1'b0);
        req = 3'b000;
        step();
        expect_out("t6_idle", 3'b000, 3'b011, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
